wb_sram_bridge: RTL
===================

# wb_sram_bridge

Wishbone slave bridge on the 16-bit data bus between the CPU's load/store unit and on-chip synchronous SRAM. Accepts pipelined strobes from the 16-bit master: up to DEPTH back-to-back requests, with acks returned later and strictly in order. Queues the requests and performs a read-then-write for every request. Each ack therefore returns the location's prior contents, for stores as well as loads, which is the data the load/store unit collects on every transfer.

## Interface

- `AW`, default 16: SRAM byte-address width; SRAM holds 2^(AW-1) half-words.
- `DEPTH`, default 4: request FIFO depth; power of two, ≥4 so a dword transfer never stalls.

Clock and reset:
- `clk_i`, in, 1: clock.
- `reset_i`, in, 1: one clock; reset is synchronous and active-low. Low at a rising edge resets the block.

Wishbone slave side:
- `wbsadr_i`, in, 64: byte address. Bit 0 ignored; bits above AW-1 ignored (aliasing).
- `wbsdat_i`, in, 16: write data.
- `wbswe_i`, in, 1: write enable.
- `wbsstb_i`, in, 1: request strobe, one request per cycle.
- `wbsstall_o`, out, 1: FIFO full; strobe not accepted.
- `wbsack_o`, out, 1: one-cycle pulse per completed request.
- `wbsdat_o`, out, 16: prior SRAM contents; valid while `wbsack_o` is high.

SRAM side:
- `sram_adr_o`, out, AW-1: half-word address.
- `sram_dat_o`, out, 16: write data.
- `sram_dat_i`, in, 16: read data, valid the cycle after a read-enable cycle.
- `sram_en_o`, out, 1: access enable.
- `sram_we_o`, out, 1: write when `sram_en_o` is also high.

## Operation

- **Push.** At each rising edge with `wbsstb_i & ~wbsstall_o`, {adr[AW-1:1], dat, we} is pushed into the FIFO.
- **Stall.** `wbsstall_o` = (count == DEPTH), driven from the registered count. A strobe while stalled is dropped; the master must retry.
- **FSM states**, all outputs registered:
  - IDLE: if FIFO non-empty, pop head into working regs → READ. Else stay.
  - READ: `sram_en_o`=1, `sram_we_o`=0, `sram_adr_o`=working addr → CAPT.
  - CAPT: `sram_dat_i` valid. Register it into `wbsdat_o`.
    - we=1 → WRITE.
    - we=0 and FIFO non-empty → pop next → READ.
    - we=0 and FIFO empty → IDLE.
    - `wbsack_o`=1 in the cycle following CAPT, whichever state that is.
  - WRITE: `sram_en_o`=1, `sram_we_o`=1, `sram_dat_o`=working data, ack high. FIFO non-empty → pop → READ; else → IDLE.
- **Throughput:** read 2 cycles/request, write 3 cycles/request.
- **Ordering:** acks in push order, exactly one per accepted strobe.
- **Push and pop in the same edge:** count unchanged. Pop from empty never occurs.
- **FIFO pointers:** wrap modulo DEPTH. Count width is log2(DEPTH)+1.
- **Reset (`reset_i` low at an edge):** every output is 0 from the next cycle.
  - Outputs cleared: `wbsack_o`, `wbsdat_o`, `wbsstall_o`, `sram_en_o`, `sram_we_o`, `sram_adr_o`, `sram_dat_o`.
  - FIFO emptied, FSM → IDLE.
- **Reset mid-operation:** pending and in-flight requests are dropped with no ack, and a scheduled WRITE is not issued.

## Timing

- A strobe accepted at edge E0 into an idle, empty bridge produces:
  - READ during cycle E1–E2;
  - `sram_dat_i` valid in E2–E3;
  - `wbsack_o` in E3–E4, i.e. 3 cycles after acceptance.
- For a write, the ack cycle and the `sram_we_o` cycle coincide.
- A read request immediately following another read is popped on the edge leaving CAPT, so its READ cycle coincides with the previous ack cycle.

## Structure

- Shared package `kcp53k_bus_pkg`: FSM state encoding (IDLE, READ, CAPT, WRITE) and the request-record width constant 16+1+(AW-1).
- Sub-module `req_fifo`: parameterised synchronous FIFO (WIDTH, DEPTH) with push, pop, full, empty, head, and the same synchronous active-low reset.
- FSM and datapath live in the top module.

## Test plan

All scenarios use AW=16 and DEPTH=4.

- **Reset:** hold `reset_i`=0 for one edge → all outputs 0, `wbsstall_o`=0, no ack for 10 cycles while `wbsstb_i`=0.
- **Single read:** preload SRAM[0x3BC4]=0xDEAD; strobe 1 cycle with we=0, adr 0x1122334455667788 → `sram_adr_o`=0x3BC4 with en=1, we=0 one cycle after acceptance; `wbsack_o`=1 with `wbsdat_o`=0xDEAD exactly 3 cycles after acceptance, for one cycle.
- **Store returns old data:** same address, we=1, dat 0x1100 → ack with `wbsdat_o`=0xDEAD, same cycle `sram_we_o`=1 and `sram_dat_o`=0x1100; a later read returns 0x1100.
- **Dword burst:** 4 consecutive strobes, we=1, at addresses ...778E/778C/778A/7788 with data 7766/5544/3322/1100, SRAM preloaded DEAD/BEEF/0BAD/C0DE → `wbsstall_o` never high; 4 acks in order returning DEAD, BEEF, 0BAD, C0DE; SRAM then holds the new data.
- **Overflow:** `wbsstb_i` held high for 8 cycles with writes → `wbsstall_o` rises when count reaches 4; number of acks equals number of accepted edges; no ack for dropped strobes.
- **Reset mid-burst:** assert reset after the 2nd ack of a 4-write burst → no further acks; `sram_en_o`=0 from the next cycle; the 3rd and 4th SRAM locations are unchanged.

Source files
------------

// File: rtl/kcp53k_bus_pkg.sv
// Shared definitions for the Wishbone-to-SRAM bridge: FSM state encoding and
// request record sizing.
package kcp53k_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_CAPT  = 2'd2,
    ST_WRITE = 2'd3
  } bridge_state_e;

  localparam int DATA_W = 16;

  // Queued request record: {half-word address, write data, write enable}.
  function automatic int req_width(input int aw);
    return DATA_W + 1 + (aw - 1);
  endfunction

endpackage

// File: rtl/req_fifo.sv
// Synchronous FIFO holding queued bus requests; head is visible before pop.
module req_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    // NOTE: every variable gets a default before the branches, so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW + 1)'(1);
      2'b01:   count_d = count_q - (PW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the pointers and count alone decide what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/wb_sram_bridge.sv
// Pipelined Wishbone slave that queues requests and performs a read-then-write
// on synchronous SRAM for each, acking in order with the location's prior contents.
module wb_sram_bridge
  import kcp53k_bus_pkg::*;
#(
  parameter int AW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [63:0]   wbsadr_i,
  input  logic [15:0]   wbsdat_i,
  input  logic          wbswe_i,
  input  logic          wbsstb_i,
  output logic          wbsstall_o,
  output logic          wbsack_o,
  output logic [15:0]   wbsdat_o,
  output logic [AW-2:0] sram_adr_o,
  output logic [15:0]   sram_dat_o,
  input  logic [15:0]   sram_dat_i,
  output logic          sram_en_o,
  output logic          sram_we_o
);

  localparam int REQ_W = req_width(AW);

  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [REQ_W-1:0] fifo_din, fifo_head;
  logic [AW-2:0]    head_adr;
  logic [15:0]      head_dat;
  logic             head_we;
  logic             unused_adr_bits;

  bridge_state_e state_q, state_d;
  logic [AW-2:0] wadr_q, wadr_d;
  logic [15:0]   wdat_q, wdat_d;
  logic          wwe_q, wwe_d;
  logic          ack_q, ack_d;
  logic [15:0]   rdat_q, rdat_d;
  logic [AW-2:0] adr_q, adr_d;
  logic [15:0]   sdat_q, sdat_d;
  logic          en_q, en_d;
  logic          we_q, we_d;
  logic          pop_next;

  // Byte-lane bit and bits above the SRAM window are ignored (aliasing).
  assign unused_adr_bits = ^{wbsadr_i[63:AW], wbsadr_i[0]};

  assign fifo_push = wbsstb_i && !fifo_full;
  assign fifo_din  = {wbsadr_i[AW-1:1], wbsdat_i, wbswe_i};
  assign {head_adr, head_dat, head_we} = fifo_head;
  assign fifo_pop  = pop_next;

  req_fifo #(.WIDTH(REQ_W), .DEPTH(DEPTH)) u_req_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (fifo_push),
    .din_i   (fifo_din),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  always_comb begin
    state_d  = state_q;
    wadr_d   = wadr_q;
    wdat_d   = wdat_q;
    wwe_d    = wwe_q;
    ack_d    = 1'b0;
    rdat_d   = rdat_q;
    adr_d    = adr_q;
    sdat_d   = sdat_q;
    en_d     = 1'b0;
    we_d     = 1'b0;
    pop_next = 1'b0;
    unique case (state_q)
      ST_IDLE: pop_next = !fifo_empty;
      ST_READ: state_d = ST_CAPT;
      ST_CAPT: begin
        rdat_d = sram_dat_i;
        ack_d  = 1'b1;
        if (wwe_q) begin
          state_d = ST_WRITE;
          en_d    = 1'b1;
          we_d    = 1'b1;
          adr_d   = wadr_q;
          sdat_d  = wdat_q;
        end else begin
          state_d  = ST_IDLE;
          pop_next = !fifo_empty;
        end
      end
      ST_WRITE: begin
        state_d  = ST_IDLE;
        pop_next = !fifo_empty;
      end
      default: state_d = ST_IDLE;
    endcase
    // Outputs are registered, so the READ strobe is set on the edge entering READ.
    if (pop_next) begin
      state_d = ST_READ;
      wadr_d  = head_adr;
      wdat_d  = head_dat;
      wwe_d   = head_we;
      en_d    = 1'b1;
      adr_d   = head_adr;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      wadr_q  <= '0;
      wdat_q  <= '0;
      wwe_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
      adr_q   <= '0;
      sdat_q  <= '0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wadr_q  <= wadr_d;
      wdat_q  <= wdat_d;
      wwe_q   <= wwe_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
      adr_q   <= adr_d;
      sdat_q  <= sdat_d;
      en_q    <= en_d;
      we_q    <= we_d;
    end
  end

  assign wbsstall_o = fifo_full;
  assign wbsack_o   = ack_q;
  assign wbsdat_o   = rdat_q;
  assign sram_adr_o = adr_q;
  assign sram_dat_o = sdat_q;
  assign sram_en_o  = en_q;
  assign sram_we_o  = we_q;

endmodule
